// File: rtl/pw_vault_if.sv
// Switch/strobe inputs and status outputs between the lock FSM side and the password vault.
interface pw_vault_if #(
  parameter int unsigned PW_W = 10,
  parameter int unsigned FC_W = 2
);
  logic [PW_W-1:0] SW;
  logic            savePW;
  logic            saveAT;
  logic            M;
  logic            pw_valid;
  logic [FC_W-1:0] fail_count;
  logic            lockout;

  modport master (
    output SW, savePW, saveAT,
    input  M, pw_valid, fail_count, lockout
  );

  modport slave (
    input  SW, savePW, saveAT,
    output M, pw_valid, fail_count, lockout
  );
endinterface

// File: rtl/pw_vault.sv
// Password store/compare datapath with registered match flag M and timed lockout
// after MAX_FAILS consecutive wrong attempts.
module pw_vault #(
  parameter int unsigned PW_W           = 10,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 150_000_000
) (
  input logic        clk,
  input logic        RESET,
  pw_vault_if.slave  bus
);

  localparam int unsigned FCW = $clog2(MAX_FAILS + 1);
  localparam int unsigned TW  = $clog2(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_READY   = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW_W-1:0] pw_q, pw_d;
  logic [PW_W-1:0] at_q, at_d;
  logic            at_valid_q, at_valid_d;
  logic            m_q, m_d;
  logic            pw_valid_q, pw_valid_d;
  logic [FCW-1:0]  fc_q, fc_d;
  logic            lock_q, lock_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            save_pw_q, save_at_q;

  logic pw_rise, at_rise, at_fall;
  logic [FCW-1:0] fc_inc;

  assign pw_rise = bus.savePW & ~save_pw_q;
  assign at_rise = bus.saveAT & ~save_at_q;
  assign at_fall = ~bus.saveAT & save_at_q;
  assign fc_inc  = (fc_q == FCW'(MAX_FAILS)) ? fc_q : fc_q + FCW'(1);

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= S_EMPTY;
      pw_q       <= '0;
      at_q       <= '0;
      at_valid_q <= 1'b0;
      m_q        <= 1'b0;
      pw_valid_q <= 1'b0;
      fc_q       <= '0;
      lock_q     <= 1'b0;
      timer_q    <= '0;
      save_pw_q  <= 1'b0;
      save_at_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pw_q       <= pw_d;
      at_q       <= at_d;
      at_valid_q <= at_valid_d;
      m_q        <= m_d;
      pw_valid_q <= pw_valid_d;
      fc_q       <= fc_d;
      lock_q     <= lock_d;
      timer_q    <= timer_d;
      save_pw_q  <= bus.savePW;
      save_at_q  <= bus.saveAT;
    end
  end

  // Password load overrides everything; otherwise capture, compare, commit or count down.
  always_comb begin
    state_d    = state_q;
    pw_d       = pw_q;
    at_d       = at_q;
    at_valid_d = at_valid_q;
    m_d        = m_q;
    pw_valid_d = pw_valid_q;
    fc_d       = fc_q;
    lock_d     = lock_q;
    timer_d    = timer_q;

    if (pw_rise) begin
      state_d    = S_READY;
      pw_d       = bus.SW;
      pw_valid_d = 1'b1;
      fc_d       = '0;
      lock_d     = 1'b0;
      timer_d    = '0;
      at_valid_d = 1'b0;
      m_d        = 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          m_d = 1'b0;
        end
        S_READY: begin
          if (at_rise) begin
            at_d       = bus.SW;
            at_valid_d = 1'b1;
          end else if (at_fall && at_valid_q) begin
            m_d        = 1'b0;
            at_valid_d = 1'b0;
            if (at_q == pw_q) begin
              fc_d = '0;
            end else begin
              fc_d = fc_inc;
              if (fc_inc == FCW'(MAX_FAILS)) begin
                state_d = S_LOCKOUT;
                lock_d  = 1'b1;
                timer_d = TW'(LOCKOUT_CYCLES - 1);
              end
            end
          end else if (bus.saveAT && at_valid_q) begin
            m_d = (at_q == pw_q);
          end else begin
            m_d = 1'b0;
          end
        end
        S_LOCKOUT: begin
          m_d = 1'b0;
          if (timer_q == '0) begin
            state_d = S_READY;
            lock_d  = 1'b0;
            fc_d    = '0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  assign bus.M          = m_q;
  assign bus.pw_valid   = pw_valid_q;
  assign bus.fail_count = fc_q;
  assign bus.lockout    = lock_q;

endmodule

// File: tb/tb_pw_vault.sv
// Directed scenario bench for pw_vault (PW_W=10, MAX_FAILS=3, LOCKOUT_CYCLES=20).
module tb_pw_vault;

  logic clk = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  pw_vault_if #(.PW_W(10), .FC_W(2)) bus ();

  pw_vault #(.PW_W(10), .MAX_FAILS(3), .LOCKOUT_CYCLES(20)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  // Advance one edge; outputs then reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold saveAT for 'hold' edges (SW switches to 'late' after capture edge), then release for one edge.
  task automatic attempt(input logic [9:0] code, input logic [9:0] late, input int hold,
                         output logic m_any, output logic m_last);
    bus.SW = code; bus.saveAT = 1'b1;
    tick();
    bus.SW = late;
    m_any  = bus.M;
    m_last = bus.M;
    for (int i = 1; i < hold; i++) begin
      tick();
      m_any  = m_any | bus.M;
      m_last = bus.M;
    end
    bus.saveAT = 1'b0;
    tick();
  endtask

  task automatic load_pw(input logic [9:0] code);
    bus.SW = code; bus.savePW = 1'b1;
    tick();
    bus.savePW = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1; bus.SW = '0; bus.savePW = 1'b0; bus.saveAT = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    n_checks++; if (bus.M !== 1'b0) $display("FAIL reset_m: got %b want 0", bus.M); else n_pass++;
    n_checks++; if (bus.pw_valid !== 1'b0) $display("FAIL reset_pw_valid: got %b want 0", bus.pw_valid); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd0) $display("FAIL reset_fail_count: got %0d want 0", bus.fail_count); else n_pass++;
    n_checks++; if (bus.lockout !== 1'b0) $display("FAIL reset_lockout: got %b want 0", bus.lockout); else n_pass++;
  endtask

  task automatic test_store_match();
    logic m0;
    bus.SW = 10'h2A5; bus.savePW = 1'b1;
    tick();
    n_checks++; if (bus.pw_valid !== 1'b1) $display("FAIL store_pw_valid: got %b want 1", bus.pw_valid); else n_pass++;
    repeat (4) tick();
    bus.savePW = 1'b0;
    tick();
    bus.saveAT = 1'b1;
    tick();
    m0 = bus.M;
    n_checks++; if (m0 !== 1'b0) $display("FAIL match_capture_edge_m: got %b want 0", m0); else n_pass++;
    tick();
    n_checks++; if (bus.M !== 1'b1) $display("FAIL match_second_edge_m: got %b want 1", bus.M); else n_pass++;
    repeat (4) tick();
    n_checks++; if (bus.M !== 1'b1) $display("FAIL match_held_m: got %b want 1", bus.M); else n_pass++;
    bus.saveAT = 1'b0;
    tick();
    n_checks++; if (bus.M !== 1'b0) $display("FAIL match_after_fall_m: got %b want 0", bus.M); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd0) $display("FAIL match_after_fall_fc: got %0d want 0", bus.fail_count); else n_pass++;
  endtask

  task automatic test_sw_change();
    logic m_any, m_last;
    attempt(10'h2A5, 10'h000, 6, m_any, m_last);
    n_checks++; if (m_last !== 1'b1) $display("FAIL swchange_m: got %b want 1", m_last); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd0) $display("FAIL swchange_fc: got %0d want 0", bus.fail_count); else n_pass++;
  endtask

  task automatic test_lockout();
    logic m_any, m_last;
    logic [1:0] exp_fc;
    for (int k = 1; k <= 3; k++) begin
      attempt(10'h001, 10'h001, 3, m_any, m_last);
      exp_fc = 2'(k);
      n_checks++; if (m_any !== 1'b0) $display("FAIL wrong_attempt_m_%0d: got %b want 0", k, m_any); else n_pass++;
      n_checks++; if (bus.fail_count !== exp_fc) $display("FAIL wrong_attempt_fc_%0d: got %0d want %0d", k, bus.fail_count, exp_fc); else n_pass++;
    end
    n_checks++; if (bus.lockout !== 1'b1) $display("FAIL lockout_entry: got %b want 1", bus.lockout); else n_pass++;
    // 4 edges consumed here, lockout entered 20 edges before it must drop
    attempt(10'h2A5, 10'h2A5, 3, m_any, m_last);
    n_checks++; if (m_any !== 1'b0) $display("FAIL lockout_attempt_m: got %b want 0", m_any); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd3) $display("FAIL lockout_attempt_fc: got %0d want 3", bus.fail_count); else n_pass++;
    repeat (15) tick();
    n_checks++; if (bus.lockout !== 1'b1) $display("FAIL lockout_last_cycle: got %b want 1", bus.lockout); else n_pass++;
    tick();
    n_checks++; if (bus.lockout !== 1'b0) $display("FAIL lockout_expire: got %b want 0", bus.lockout); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd0) $display("FAIL lockout_expire_fc: got %0d want 0", bus.fail_count); else n_pass++;
  endtask

  task automatic test_reset_count();
    logic m_any, m_last;
    logic lock_seen;
    attempt(10'h3FF, 10'h3FF, 3, m_any, m_last);
    lock_seen = bus.lockout;
    attempt(10'h0A5, 10'h0A5, 3, m_any, m_last);
    lock_seen |= bus.lockout;
    n_checks++; if (bus.fail_count !== 2'd2) $display("FAIL two_wrong_fc: got %0d want 2", bus.fail_count); else n_pass++;
    attempt(10'h2A5, 10'h2A5, 3, m_any, m_last);
    lock_seen |= bus.lockout;
    n_checks++; if (m_last !== 1'b1) $display("FAIL correct_after_wrong_m: got %b want 1", m_last); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd0) $display("FAIL correct_clears_fc: got %0d want 0", bus.fail_count); else n_pass++;
    n_checks++; if (lock_seen !== 1'b0) $display("FAIL no_lockout_seen: got %b want 0", lock_seen); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic m_any, m_last;
    bus.SW = 10'h155; bus.savePW = 1'b1; bus.saveAT = 1'b1;
    tick();
    m_any = bus.M;
    repeat (3) begin tick(); m_any |= bus.M; end
    bus.savePW = 1'b0; bus.saveAT = 1'b0;
    tick();
    n_checks++; if (m_any !== 1'b0) $display("FAIL simul_rise_m: got %b want 0", m_any); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd0) $display("FAIL simul_rise_fc: got %0d want 0", bus.fail_count); else n_pass++;
    attempt(10'h155, 10'h155, 3, m_any, m_last);
    n_checks++; if (m_last !== 1'b1) $display("FAIL simul_rise_pw_loaded: got %b want 1", m_last); else n_pass++;
    repeat (3) attempt(10'h000, 10'h000, 2, m_any, m_last);
    n_checks++; if (bus.lockout !== 1'b1) $display("FAIL relock_entry: got %b want 1", bus.lockout); else n_pass++;
    bus.SW = 10'h0F0; bus.savePW = 1'b1;
    tick();
    n_checks++; if (bus.lockout !== 1'b0) $display("FAIL pw_rise_clears_lockout: got %b want 0", bus.lockout); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd0) $display("FAIL pw_rise_clears_fc: got %0d want 0", bus.fail_count); else n_pass++;
    bus.savePW = 1'b0;
    tick();
    attempt(10'h0F0, 10'h0F0, 3, m_any, m_last);
    n_checks++; if (m_last !== 1'b1) $display("FAIL new_pw_match: got %b want 1", m_last); else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic m_any, m_last;
    repeat (3) attempt(10'h001, 10'h001, 2, m_any, m_last);
    n_checks++; if (bus.lockout !== 1'b1) $display("FAIL midreset_lock_setup: got %b want 1", bus.lockout); else n_pass++;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    n_checks++; if (bus.lockout !== 1'b0) $display("FAIL midreset_lockout: got %b want 0", bus.lockout); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd0) $display("FAIL midreset_fc: got %0d want 0", bus.fail_count); else n_pass++;
    n_checks++; if (bus.pw_valid !== 1'b0) $display("FAIL midreset_pw_valid: got %b want 0", bus.pw_valid); else n_pass++;
    load_pw(10'h3FF);
    bus.SW = 10'h3FF; bus.saveAT = 1'b1;
    tick(); tick();
    n_checks++; if (bus.M !== 1'b1) $display("FAIL midreset_attempt_setup: got %b want 1", bus.M); else n_pass++;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    n_checks++; if ({bus.M, bus.pw_valid, bus.lockout, bus.fail_count} !== 5'b0)
      $display("FAIL midattempt_reset_outputs: got %b want 00000", {bus.M, bus.pw_valid, bus.lockout, bus.fail_count});
    else n_pass++;
    bus.saveAT = 1'b0;
    tick();
    attempt(10'h000, 10'h000, 3, m_any, m_last);
    n_checks++; if (m_any !== 1'b0) $display("FAIL empty_state_m: got %b want 0", m_any); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd0) $display("FAIL empty_state_fc: got %0d want 0", bus.fail_count); else n_pass++;
  endtask

  initial begin
    RESET = 1'b1;
    bus.SW = '0; bus.savePW = 1'b0; bus.saveAT = 1'b0;
    test_reset();
    test_store_match();
    test_sw_change();
    test_lockout();
    test_reset_count();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
